// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default channel count, resolution and on-level, plus
// packed on-time vector helpers used by both the PWM generator and pwm_meas.
// Latency: n/a (constants and a combinational helper). Backpressure: n/a.
package pwm_pkg;

  localparam int   DEF_NO_CHANNELS    = 16;
  localparam int   DEF_PWM_RESOLUTION = 16;
  localparam logic DEF_LED_ON_VAL     = 1'b1;
  localparam int   ON_VEC_W           = DEF_NO_CHANNELS * DEF_PWM_RESOLUTION;

  // Channel idx slice of a packed on-time vector (default geometry).
  function automatic logic [DEF_PWM_RESOLUTION-1:0] chan_slice(
    input logic [ON_VEC_W-1:0] vec,
    input int unsigned         idx
  );
    return vec[idx*DEF_PWM_RESOLUTION +: DEF_PWM_RESOLUTION];
  endfunction

endpackage

// File: rtl/pwm_meas_chan.sv
// One measurement channel: input staging, saturating on-cycle counter, edge flag.
// Latency: 1 staging cycle (2 with PWM_MEAS_SYNC_EN); m_o/edge_o are combinational.
// Backpressure: none; the channel samples every cycle and is cleared by the top.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   pwm_i          raw PWM line
//   clr_i          restart (measurement disabled or sync pulse)
//   win_last_i     last cycle of the current window
//   m_o            on-cycle count for the window ending this cycle (saturating)
//   edge_o         an off->on transition was seen in the window ending this cycle
// Build option: PWM_MEAS_SYNC_EN selects a two-flop synchronizer instead of
// a single input register.
module pwm_meas_chan
  import pwm_pkg::*;
#(
  parameter int   P_PWM_RESOLUTION = DEF_PWM_RESOLUTION,
  parameter logic P_LED_ON_VAL     = DEF_LED_ON_VAL
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        pwm_i,
  input  logic                        clr_i,
  input  logic                        win_last_i,
  output logic [P_PWM_RESOLUTION-1:0] m_o,
  output logic                        edge_o
);

  localparam logic [P_PWM_RESOLUTION-1:0] CNT_ONE = {{(P_PWM_RESOLUTION-1){1'b0}}, 1'b1};

  logic staged;

`ifdef PWM_MEAS_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {2{~P_LED_ON_VAL}};
    else       sync_q <= {sync_q[0], pwm_i};
  end

  assign staged = sync_q[1];
`else
  logic stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stage_q <= ~P_LED_ON_VAL;
    else       stage_q <= pwm_i;
  end

  assign staged = stage_q;
`endif

  logic [P_PWM_RESOLUTION-1:0] on_cntr_q, on_cntr_d;
  logic                        prev_q;
  logic                        edge_acc_q, edge_acc_d;
  logic                        on_lvl, prev_on, rise, cnt_full;

  assign on_lvl   = (staged == P_LED_ON_VAL);
  // prev_q keeps the raw staged level so its reset value means "off".
  assign prev_on  = (prev_q == P_LED_ON_VAL);
  assign rise     = on_lvl & ~prev_on;
  assign cnt_full = &on_cntr_q;

  // A window-closing cycle clears the counter so the next window starts empty;
  // its own on-level and rise are folded into m_o/edge_o instead.
  always_comb begin
    on_cntr_d  = on_cntr_q;
    edge_acc_d = edge_acc_q;
    if (clr_i || win_last_i) begin
      on_cntr_d  = '0;
      edge_acc_d = 1'b0;
    end else begin
      if (on_lvl && !cnt_full) on_cntr_d = on_cntr_q + CNT_ONE;
      if (rise)                edge_acc_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      on_cntr_q  <= '0;
      prev_q     <= ~P_LED_ON_VAL;
      edge_acc_q <= 1'b0;
    end else begin
      on_cntr_q  <= on_cntr_d;
      prev_q     <= staged;
      edge_acc_q <= edge_acc_d;
    end
  end

  // A fully-on window is 2^N cycles and saturates to all-ones.
  assign m_o    = (on_lvl && !cnt_full) ? (on_cntr_q + CNT_ONE) : on_cntr_q;
  assign edge_o = edge_acc_q | rise;

endmodule

// File: rtl/pwm_meas.sv
// PWM receive-side meter: per-channel on-cycle count over a 2^P_PWM_RESOLUTION window.
// Latency: result valid 2^N+1 cycles after a sync/enable restart, then every 2^N cycles.
// Backpressure: none; meas_valid_oh is a one-cycle pulse, outputs hold until the next one.
// Ports:
//   clk_ir         clock
//   rst_ih         async active-high reset
//   meas_en_ih     1 = measure, 0 = window and channel counters held at 0
//   pwm_sync_ih    single-cycle window restart; discards the partial window
//   pwm_data_id    PWM input lines, one per channel
//   meas_valid_oh  meas_vec_od / edge_seen_od were updated this cycle
//   meas_vec_od    packed on-cycle counts, channel i at [i*P_PWM_RESOLUTION +: P_PWM_RESOLUTION]
//   edge_seen_od   per channel, an off->on transition occurred in the last window
// Build option: PWM_MEAS_SYNC_EN adds a two-flop synchronizer per channel
// for asynchronous sources (see pwm_meas_chan).
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int   P_NO_CHANNELS    = DEF_NO_CHANNELS,
  parameter int   P_PWM_RESOLUTION = DEF_PWM_RESOLUTION,
  parameter logic P_LED_ON_VAL     = DEF_LED_ON_VAL,
  parameter int   P_ON_VEC_W       = P_NO_CHANNELS * P_PWM_RESOLUTION
) (
  input  logic                     clk_ir,
  input  logic                     rst_ih,
  input  logic                     meas_en_ih,
  input  logic                     pwm_sync_ih,
  input  logic [P_NO_CHANNELS-1:0] pwm_data_id,
  output logic                     meas_valid_oh,
  output logic [P_ON_VEC_W-1:0]    meas_vec_od,
  output logic [P_NO_CHANNELS-1:0] edge_seen_od
);

  localparam logic [P_PWM_RESOLUTION-1:0] CNT_ONE = {{(P_PWM_RESOLUTION-1){1'b0}}, 1'b1};

  logic [P_PWM_RESOLUTION-1:0] win_cntr_q, win_cntr_d;
  logic                        clr;
  logic                        win_last;
  logic [P_ON_VEC_W-1:0]       m_vec;
  logic [P_NO_CHANNELS-1:0]    edge_vec;

  logic                        meas_valid_q;
  logic [P_ON_VEC_W-1:0]       meas_vec_q;
  logic [P_NO_CHANNELS-1:0]    edge_seen_q;

  // Disable dominates sync; both restart the window from cycle 0.
  assign clr = ~meas_en_ih | pwm_sync_ih;

  // A sync landing on the last window cycle wins: no result for that window.
  assign win_last = (&win_cntr_q) & meas_en_ih & ~pwm_sync_ih;

  always_comb begin
    win_cntr_d = win_cntr_q + CNT_ONE;
    if (clr) win_cntr_d = '0;
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) win_cntr_q <= '0;
    else        win_cntr_q <= win_cntr_d;
  end

  for (genvar g = 0; g < P_NO_CHANNELS; g++) begin : gen_chan
    pwm_meas_chan #(
      .P_PWM_RESOLUTION (P_PWM_RESOLUTION),
      .P_LED_ON_VAL     (P_LED_ON_VAL)
    ) u_chan (
      .clk_i      (clk_ir),
      .rst_i      (rst_ih),
      .pwm_i      (pwm_data_id[g]),
      .clr_i      (clr),
      .win_last_i (win_last),
      .m_o        (m_vec[g*P_PWM_RESOLUTION +: P_PWM_RESOLUTION]),
      .edge_o     (edge_vec[g])
    );
  end

  // Results are captured only at window close and hold otherwise,
  // including while measurement is disabled.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      meas_valid_q <= 1'b0;
      meas_vec_q   <= '0;
      edge_seen_q  <= '0;
    end else begin
      meas_valid_q <= win_last;
      if (win_last) begin
        meas_vec_q  <= m_vec;
        edge_seen_q <= edge_vec;
      end
    end
  end

  assign meas_valid_oh = meas_valid_q;
  assign meas_vec_od   = meas_vec_q;
  assign edge_seen_od  = edge_seen_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Self-checking bench for pwm_meas (P_PWM_RESOLUTION=8, P_NO_CHANNELS=4).
// Expected results are queued when stimulus is applied and popped on each valid.
module tb_pwm_meas;

  localparam int NCH = 4;
  localparam int RES = 8;
  localparam int VW  = NCH * RES;
  localparam int WIN = 1 << RES;

  logic           clk_ir = 1'b0;
  logic           rst_ih;
  logic           meas_en_ih;
  logic           pwm_sync_ih;
  logic [NCH-1:0] pwm_data_id;
  logic           meas_valid_oh;
  logic [VW-1:0]  meas_vec_od;
  logic [NCH-1:0] edge_seen_od;

  logic [NCH-1:0] tb_dat;
  logic           gen_en;
  logic           gen_bit = 1'b0;
  logic [7:0]     gen_cnt = 8'd0;

  // Generator loopback replaces channel 2 when enabled.
  assign pwm_data_id = gen_en ? {tb_dat[3], gen_bit, tb_dat[1:0]} : tb_dat;

  pwm_meas #(
    .P_NO_CHANNELS    (NCH),
    .P_PWM_RESOLUTION (RES),
    .P_LED_ON_VAL     (1'b1),
    .P_ON_VEC_W       (VW)
  ) dut (
    .clk_ir        (clk_ir),
    .rst_ih        (rst_ih),
    .meas_en_ih    (meas_en_ih),
    .pwm_sync_ih   (pwm_sync_ih),
    .pwm_data_id   (pwm_data_id),
    .meas_valid_oh (meas_valid_oh),
    .meas_vec_od   (meas_vec_od),
    .edge_seen_od  (edge_seen_od)
  );

  always #5 clk_ir = ~clk_ir;

  typedef struct {
    logic [VW-1:0]  vec;
    logic [NCH-1:0] edges;
    int             cyc;
  } exp_t;

  exp_t           exp_q[$];
  int             tests_run    = 0;
  int             tests_failed = 0;
  int             cyc          = 0;
  int             valid_cnt    = 0;
  logic [VW-1:0]  last_vec;
  logic [NCH-1:0] last_edges;

  always @(posedge clk_ir) cyc <= cyc + 1;
  always @(negedge clk_ir) if (meas_valid_oh === 1'b1) valid_cnt <= valid_cnt + 1;

  // Model of the generator: on while its 8-bit counter <= 0x40, i.e. 65 of 256 cycles.
  always @(posedge clk_ir) begin
    #1;
    gen_bit = (gen_cnt <= 8'h40);
    gen_cnt = gen_cnt + 8'd1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_ir);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int at_cyc);
    ok     = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ir);
      if (meas_valid_oh === 1'b1) begin
        ok     = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  // Drive a one-cycle sync; c is the cycle index at which it was applied.
  task automatic sync_pulse(output int c);
    pwm_sync_ih = 1'b1;
    c           = cyc;
    step(1);
    pwm_sync_ih = 1'b0;
  endtask

  task automatic test_reset();
    rst_ih      = 1'b1;
    meas_en_ih  = 1'b0;
    pwm_sync_ih = 1'b0;
    tb_dat      = '0;
    gen_en      = 1'b0;
    step(3);
    tests_run++;
    if (meas_vec_od !== '0) begin
      tests_failed++;
      $display("FAIL reset_vec: got %h expected %h", meas_vec_od, 32'h0);
    end
    tests_run++;
    if (edge_seen_od !== '0) begin
      tests_failed++;
      $display("FAIL reset_edge: got %b expected %b", edge_seen_od, 4'b0);
    end
    tests_run++;
    if (meas_valid_oh !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 0", meas_valid_oh);
    end
    rst_ih = 1'b0;
    step(WIN + 10);
    tests_run++;
    if (valid_cnt !== 0) begin
      tests_failed++;
      $display("FAIL disabled_no_valid: got %0d valids expected 0", valid_cnt);
    end
  endtask

  task automatic test_window();
    int   c, at;
    bit   ok;
    exp_t e;
    meas_en_ih = 1'b1;
    tb_dat     = 4'b0001;
    step(5);
    sync_pulse(c);
    exp_q.push_back('{vec: 32'h000000FF, edges: 4'b0000, cyc: c + WIN + 1});
    wait_valid(WIN + 20, ok, at);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || at != e.cyc) begin
      tests_failed++;
      $display("FAIL window_latency: got cycle %0d expected %0d", at, e.cyc);
    end
    tests_run++;
    if (meas_vec_od !== e.vec) begin
      tests_failed++;
      $display("FAIL window_vec: got %h expected %h", meas_vec_od, e.vec);
    end
    tests_run++;
    if (edge_seen_od !== e.edges) begin
      tests_failed++;
      $display("FAIL window_edge: got %b expected %b", edge_seen_od, e.edges);
    end
    @(negedge clk_ir);
    tests_run++;
    if (meas_valid_oh !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_pulse_width: got %b expected 0 one cycle after valid", meas_valid_oh);
    end
    last_vec   = e.vec;
    last_edges = e.edges;
    step(1);
  endtask

  task automatic test_loopback();
    int   c, at, prev;
    bit   ok;
    exp_t e;
    tb_dat = '0;
    gen_en = 1'b1;
    // The window in progress is only partly loopback data; skip it.
    wait_valid(WIN + 20, ok, at);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL loopback_first: got no valid expected one within %0d cycles", WIN + 20);
    end
    prev = at;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        // Shift the window phase against the generator with a sync.
        step($urandom_range(20, 200));
        sync_pulse(c);
        exp_q.push_back('{vec: 32'h00410000, edges: 4'b0100, cyc: c + WIN + 1});
      end else begin
        exp_q.push_back('{vec: 32'h00410000, edges: 4'b0100, cyc: prev + WIN});
      end
      wait_valid(WIN + 20, ok, at);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || at != e.cyc) begin
        tests_failed++;
        $display("FAIL loopback_cycle[%0d]: got %0d expected %0d", k, at, e.cyc);
      end
      tests_run++;
      if (meas_vec_od !== e.vec) begin
        tests_failed++;
        $display("FAIL loopback_vec[%0d]: got %h expected %h", k, meas_vec_od, e.vec);
      end
      tests_run++;
      if (edge_seen_od !== e.edges) begin
        tests_failed++;
        $display("FAIL loopback_edge[%0d]: got %b expected %b", k, edge_seen_od, e.edges);
      end
      prev = at;
    end
    step(1);
  endtask

  task automatic test_glitch();
    int   c, at;
    bit   ok;
    exp_t e;
    gen_en = 1'b0;
    tb_dat = '0;
    sync_pulse(c);
    step(99);
    tb_dat[3] = 1'b1;
    step(1);
    tb_dat[3] = 1'b0;
    exp_q.push_back('{vec: 32'h01000000, edges: 4'b1000, cyc: c + WIN + 1});
    exp_q.push_back('{vec: 32'h00000000, edges: 4'b0000, cyc: c + 2*WIN + 1});
    for (int k = 0; k < 2; k++) begin
      wait_valid(WIN + 20, ok, at);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || at != e.cyc) begin
        tests_failed++;
        $display("FAIL glitch_cycle[%0d]: got %0d expected %0d", k, at, e.cyc);
      end
      tests_run++;
      if (meas_vec_od !== e.vec) begin
        tests_failed++;
        $display("FAIL glitch_vec[%0d]: got %h expected %h", k, meas_vec_od, e.vec);
      end
      tests_run++;
      if (edge_seen_od !== e.edges) begin
        tests_failed++;
        $display("FAIL glitch_edge[%0d]: got %b expected %b", k, edge_seen_od, e.edges);
      end
    end
    step(1);
  endtask

  task automatic test_sync_restart();
    int   c, d1, d2, at, vc;
    bit   ok;
    exp_t e;
    tb_dat = 4'b0101;
    step(5);
    sync_pulse(c);
    vc = valid_cnt;
    step(100);
    sync_pulse(d1);   // window cycle 100
    step(WIN - 1);
    sync_pulse(d2);   // lands on the last cycle of the restarted window
    tests_run++;
    if (valid_cnt !== vc) begin
      tests_failed++;
      $display("FAIL sync_truncated_valid: got %0d valids expected 0", valid_cnt - vc);
    end
    exp_q.push_back('{vec: 32'h00FF00FF, edges: 4'b0000, cyc: d2 + WIN + 1});
    wait_valid(WIN + 20, ok, at);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || at != e.cyc) begin
      tests_failed++;
      $display("FAIL sync_cycle: got %0d expected %0d", at, e.cyc);
    end
    tests_run++;
    if (meas_vec_od !== e.vec) begin
      tests_failed++;
      $display("FAIL sync_vec: got %h expected %h", meas_vec_od, e.vec);
    end
    tests_run++;
    if (edge_seen_od !== e.edges) begin
      tests_failed++;
      $display("FAIL sync_edge: got %b expected %b", edge_seen_od, e.edges);
    end
    last_vec   = e.vec;
    last_edges = e.edges;
    step(1);
  endtask

  task automatic test_enable_gap();
    int   c, d1, at, vc;
    bit   ok;
    exp_t e;
    sync_pulse(c);
    vc = valid_cnt;
    step(79);
    meas_en_ih = 1'b0;
    step(20);
    tb_dat = 4'b0001;  // changes while disabled must not leak into the next window
    tests_run++;
    if (meas_vec_od !== last_vec) begin
      tests_failed++;
      $display("FAIL enable_hold_vec: got %h expected %h", meas_vec_od, last_vec);
    end
    tests_run++;
    if (edge_seen_od !== last_edges) begin
      tests_failed++;
      $display("FAIL enable_hold_edge: got %b expected %b", edge_seen_od, last_edges);
    end
    step(30);
    tests_run++;
    if (valid_cnt !== vc) begin
      tests_failed++;
      $display("FAIL enable_gap_valid: got %0d valids expected 0", valid_cnt - vc);
    end
    meas_en_ih = 1'b1;
    d1 = cyc;          // last disabled cycle is d1-1
    exp_q.push_back('{vec: 32'h000000FF, edges: 4'b0000, cyc: d1 - 1 + WIN + 1});
    wait_valid(WIN + 20, ok, at);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || at != e.cyc) begin
      tests_failed++;
      $display("FAIL enable_cycle: got %0d expected %0d", at, e.cyc);
    end
    tests_run++;
    if (meas_vec_od !== e.vec) begin
      tests_failed++;
      $display("FAIL enable_vec: got %h expected %h", meas_vec_od, e.vec);
    end
    tests_run++;
    if (edge_seen_od !== e.edges) begin
      tests_failed++;
      $display("FAIL enable_edge: got %b expected %b", edge_seen_od, e.edges);
    end
    step(1);
  endtask

  task automatic test_async_reset();
    int   dr, at;
    bit   ok;
    exp_t e;
    step(40);
    #2;
    rst_ih = 1'b1;
    #1;
    tests_run++;
    if (meas_vec_od !== '0) begin
      tests_failed++;
      $display("FAIL areset_vec: got %h expected %h", meas_vec_od, 32'h0);
    end
    tests_run++;
    if (edge_seen_od !== '0) begin
      tests_failed++;
      $display("FAIL areset_edge: got %b expected %b", edge_seen_od, 4'b0);
    end
    tests_run++;
    if (meas_valid_oh !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_valid: got %b expected 0", meas_valid_oh);
    end
    step(2);
    rst_ih = 1'b0;
    dr = cyc;
    // Staging is off in window cycle 0, on for the remaining 255; prev resets to off.
    exp_q.push_back('{vec: 32'h000000FF, edges: 4'b0001, cyc: dr + WIN});
    wait_valid(WIN + 20, ok, at);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || at != e.cyc) begin
      tests_failed++;
      $display("FAIL areset_cycle: got %0d expected %0d", at, e.cyc);
    end
    tests_run++;
    if (meas_vec_od !== e.vec) begin
      tests_failed++;
      $display("FAIL areset_after_vec: got %h expected %h", meas_vec_od, e.vec);
    end
    tests_run++;
    if (edge_seen_od !== e.edges) begin
      tests_failed++;
      $display("FAIL areset_after_edge: got %b expected %b", edge_seen_od, e.edges);
    end
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_window();
    test_loopback();
    test_glitch();
    test_sync_restart();
    test_enable_gap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
